// File: rtl/acs_pmu.sv
// Add-compare-select / path-metric unit for a K=3, rate-1/2 Viterbi decoder (4 states).
// Build option: define ACS_NORM_EN to get MSB normalisation; otherwise metrics saturate.
module acs_node #(
   parameter int BM_W = 2,
   parameter int PM_W = 6
) (
   input  logic [PM_W-1:0] pm_even_i,
   input  logic [PM_W-1:0] pm_odd_i,
   input  logic [BM_W-1:0] bm_even_i,
   input  logic [BM_W-1:0] bm_odd_i,
   output logic [PM_W:0]   sum_o,
   output logic            dec_o
);
   logic [PM_W:0] cand0, cand1;

   // One extra bit so the add never wraps before the saturate/normalise stage
   assign cand0 = {1'b0, pm_even_i} + (PM_W+1)'(bm_even_i);
   assign cand1 = {1'b0, pm_odd_i}  + (PM_W+1)'(bm_odd_i);
   assign dec_o = (cand1 < cand0);
   assign sum_o = dec_o ? cand1 : cand0;
endmodule

module acs_pmu #(
   parameter int BM_W    = 2,
   parameter int PM_W    = 6,
   parameter int INIT_PM = 8,
   parameter int CNT_W   = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                refresh,
   input  logic                valid_in,
   input  logic [BM_W-1:0]     bm_00,
   input  logic [BM_W-1:0]     bm_01,
   input  logic [BM_W-1:0]     bm_10,
   input  logic [BM_W-1:0]     bm_11,
   output logic [3:0]          dec_out,
   output logic [4*PM_W-1:0]   pm_out,
   output logic [1:0]          best_state,
   output logic [CNT_W-1:0]    sym_cnt,
   output logic                norm_evt,
   output logic                valid_out
);
   localparam logic [PM_W-1:0] INIT = PM_W'(INIT_PM);
   localparam logic [3:0][PM_W-1:0] PM_INIT = {INIT, INIT, INIT, {PM_W{1'b0}}};

   logic [3:0][PM_W-1:0] pm_q, pm_old, pm_d;
   logic [3:0][PM_W:0]   sums;
   logic [3:0]           dec_d, dec_q;
   logic [3:0][BM_W-1:0] bm;
   logic [1:0]           best_d, best_q;
   logic                 norm_d, norm_q, vout_q;
   logic [CNT_W-1:0]     cnt_base, cnt_d, cnt_q;

   assign bm     = {bm_11, bm_10, bm_01, bm_00};
   // A symbol that arrives with refresh is the first of the new frame
   assign pm_old = refresh ? PM_INIT : pm_q;

   // ns{u,a}: predecessors {a,0}/{a,1}; bm index = expected {c0,c1}
   for (genvar g = 0; g < 4; g++) begin : g_acs
      localparam int PE = (g % 2) * 2;
      localparam int EI = (g == 0) ? 0 : (g == 1) ? 2 : (g == 2) ? 3 : 1;
      localparam int OI = (g == 0) ? 3 : (g == 1) ? 1 : (g == 2) ? 0 : 2;
      acs_node #(.BM_W(BM_W), .PM_W(PM_W)) u_acs (
         .pm_even_i (pm_old[PE]),
         .pm_odd_i  (pm_old[PE+1]),
         .bm_even_i (bm[EI]),
         .bm_odd_i  (bm[OI]),
         .sum_o     (sums[g]),
         .dec_o     (dec_d[g])
      );
   end

   always_comb begin
      pm_d   = '0;
      norm_d = 1'b0;
      for (int i = 0; i < 4; i++)
         pm_d[i] = sums[i][PM_W] ? {PM_W{1'b1}} : sums[i][PM_W-1:0];
`ifdef ACS_NORM_EN
      norm_d = pm_d[0][PM_W-1] & pm_d[1][PM_W-1] & pm_d[2][PM_W-1] & pm_d[3][PM_W-1];
      if (norm_d)
         for (int i = 0; i < 4; i++) pm_d[i][PM_W-1] = 1'b0;
`endif
   end

   always_comb begin
      best_d = 2'd0;
      for (int i = 1; i < 4; i++)
         if (pm_d[i] < pm_d[best_d]) best_d = 2'(i);
   end

   always_comb begin
      cnt_base = refresh ? '0 : cnt_q;
      cnt_d    = cnt_base;
      if (valid_in && cnt_base != {CNT_W{1'b1}}) cnt_d = cnt_base + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pm_q   <= PM_INIT;
         dec_q  <= '0;
         best_q <= '0;
         norm_q <= 1'b0;
         vout_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         vout_q <= valid_in;
         cnt_q  <= cnt_d;
         if (valid_in) begin
            pm_q   <= pm_d;
            dec_q  <= dec_d;
            best_q <= best_d;
            norm_q <= norm_d;
         end else if (refresh) begin
            pm_q   <= PM_INIT;
         end
      end
   end

   assign pm_out     = pm_q;
   assign dec_out    = dec_q;
   assign best_state = best_q;
   assign norm_evt   = norm_q;
   assign valid_out  = vout_q;
   assign sym_cnt    = cnt_q;
endmodule

// File: tb/tb_acs_pmu.sv
// Directed-vector bench for acs_pmu: trellis table, refresh/reset corners, growth, counter saturation.
module tb_acs_pmu;
   logic       clk = 1'b0;
   logic       rst, refresh, valid_in;
   logic [1:0] bm_00, bm_01, bm_10, bm_11;
   logic [3:0] dec_out;
   logic [23:0] pm_out;
   logic [1:0] best_state;
   logic [7:0] sym_cnt;
   logic       norm_evt, valid_out;

   int n_chk = 0;
   int n_fail = 0;

   acs_pmu dut (
      .clk(clk), .rst(rst), .refresh(refresh), .valid_in(valid_in),
      .bm_00(bm_00), .bm_01(bm_01), .bm_10(bm_10), .bm_11(bm_11),
      .dec_out(dec_out), .pm_out(pm_out), .best_state(best_state),
      .sym_cnt(sym_cnt), .norm_evt(norm_evt), .valid_out(valid_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic r, f, v;
      int   b0, b1, b2, b3;
      int   p0, p1, p2, p3;
      int   dec, best, cnt, vo;
      logic ca;
   } vec_t;

   vec_t tv[16];

   function automatic vec_t mk(input logic r, f, v, input int b0, b1, b2, b3,
                               input int p0, p1, p2, p3, dec, best, cnt, vo,
                               input logic ca);
      vec_t t;
      t.r = r; t.f = f; t.v = v;
      t.b0 = b0; t.b1 = b1; t.b2 = b2; t.b3 = b3;
      t.p0 = p0; t.p1 = p1; t.p2 = p2; t.p3 = p3;
      t.dec = dec; t.best = best; t.cnt = cnt; t.vo = vo; t.ca = ca;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step(input logic r, f, v, input int b0, b1, b2, b3);
      rst = r; refresh = f; valid_in = v;
      bm_00 = 2'(b0); bm_01 = 2'(b1); bm_10 = 2'(b2); bm_11 = 2'(b3);
      @(posedge clk);
      #1;
   endtask

   function automatic int pm(input int i);
      return int'(pm_out[i*6 +: 6]);
   endfunction

   initial begin
      int e;
      logic en;
      rst = 1'b1; refresh = 1'b0; valid_in = 1'b0;
      bm_00 = '0; bm_01 = '0; bm_10 = '0; bm_11 = '0;

      //          r f v  bm00..bm11    pm0..pm3       dec  best cnt vo ca
      tv[0]  = mk(1,0,0, 0,0,0,0,      0,8,8,8,       0,   0,   0,  0, 1);
      tv[1]  = mk(1,0,0, 0,0,0,0,      0,8,8,8,       0,   0,   0,  0, 1);
      tv[2]  = mk(0,0,1, 0,1,1,2,      0,9,2,9,       0,   0,   1,  1, 1);
      tv[3]  = mk(0,0,0, 3,3,3,3,      0,9,2,9,       0,   0,   1,  0, 0);
      tv[4]  = mk(0,0,1, 2,1,1,0,      2,3,0,3,       0,   2,   2,  1, 1);
      tv[5]  = mk(0,0,1, 2,0,2,0,      3,2,2,0,       1,   3,   3,  1, 1);
      tv[6]  = mk(0,0,1, 1,1,1,1,      3,1,3,1,       15,  1,   4,  1, 1);
      tv[7]  = mk(0,0,1, 0,0,0,0,      1,1,1,1,       15,  0,   5,  1, 1);
      tv[8]  = mk(0,0,0, 0,0,0,0,      1,1,1,1,       15,  0,   5,  0, 0);
      tv[9]  = mk(0,1,1, 0,1,1,2,      0,9,2,9,       0,   0,   1,  1, 1);
      tv[10] = mk(0,0,0, 2,2,2,2,      0,9,2,9,       0,   0,   1,  0, 0);
      tv[11] = mk(0,0,1, 2,1,1,0,      2,3,0,3,       0,   2,   2,  1, 1);
      tv[12] = mk(0,1,0, 0,0,0,0,      0,8,8,8,       0,   0,   0,  0, 0);
      tv[13] = mk(0,0,1, 2,1,1,0,      2,9,0,9,       0,   2,   1,  1, 1);
      tv[14] = mk(1,1,1, 0,1,1,2,      0,8,8,8,       0,   0,   0,  0, 1);
      tv[15] = mk(0,0,1, 1,2,0,1,      1,8,1,8,       8,   0,   1,  1, 1);

      for (int k = 0; k < 16; k++) begin
         step(tv[k].r, tv[k].f, tv[k].v, tv[k].b0, tv[k].b1, tv[k].b2, tv[k].b3);
         chk($sformatf("v%0d pm0", k), pm(0), tv[k].p0);
         chk($sformatf("v%0d pm1", k), pm(1), tv[k].p1);
         chk($sformatf("v%0d pm2", k), pm(2), tv[k].p2);
         chk($sformatf("v%0d pm3", k), pm(3), tv[k].p3);
         chk($sformatf("v%0d dec", k), dec_out, tv[k].dec);
         chk($sformatf("v%0d cnt", k), sym_cnt, tv[k].cnt);
         chk($sformatf("v%0d vout", k), valid_out, tv[k].vo);
         if (tv[k].ca) begin
            chk($sformatf("v%0d best", k), best_state, tv[k].best);
            chk($sformatf("v%0d norm", k), norm_evt, 0);
         end
      end

      // Metric growth with worst-case branch metrics from reset
      step(1,0,0, 0,0,0,0);
      step(1,0,0, 0,0,0,0);
      step(0,0,1, 3,3,3,3);
      chk("grow1 pm0", pm(0), 3);
      chk("grow1 pm1", pm(1), 11);
      chk("grow1 pm2", pm(2), 3);
      chk("grow1 pm3", pm(3), 11);
      e = 3;
      for (int k = 2; k <= 25; k++) begin
         step(0,0,1, 3,3,3,3);
         e  = e + 3;
         en = 1'b0;
`ifdef ACS_NORM_EN
         if (e >= 32) begin e = e - 32; en = 1'b1; end
`else
         if (e > 63) e = 63;
`endif
         for (int i = 0; i < 4; i++) chk($sformatf("grow%0d pm%0d", k, i), pm(i), e);
         chk($sformatf("grow%0d norm", k), norm_evt, en);
         chk($sformatf("grow%0d cnt", k), sym_cnt, k);
      end

      // Counter saturation
      for (int k = 26; k <= 254; k++) step(0,0,1, 0,0,0,0);
      chk("cnt 254", sym_cnt, 254);
      step(0,0,1, 0,0,0,0);
      chk("cnt 255", sym_cnt, 255);
      step(0,0,1, 0,0,0,0);
      chk("cnt sat", sym_cnt, 255);
      step(0,0,0, 0,0,0,0);
      chk("cnt idle", sym_cnt, 255);
      chk("vout idle", valid_out, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
